// File: rtl/line_window_buf_if.sv
// line_window_buf_if
//   Pixel-stream bundle for the vertical-window line buffer.
//   Handshake: the producer asserts din_vld for every cycle din carries a pixel;
//   there is no back-pressure, so a pixel is taken on any rising edge where
//   din_vld=1 (and, while idle, din_sof=1). dout_vld marks each cycle in which
//   dout_col and its flags carry a window column; it is a one-cycle strobe.
//   master : pixel producer (drives din/din_vld/din_sof, observes outputs)
//   slave  : line buffer (consumes din side, drives dout_* / sync_err / dbg_state)
//   dbg_state exposes the buffer's frame FSM (0 = IDLE, 1 = FILL, 2 = RUN).
interface line_window_buf_if #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 5,
    parameter int COL    = 640,
    parameter int ROW    = 480
);
    localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;

    logic [DATA_W-1:0]      din;
    logic                   din_vld;
    logic                   din_sof;
    logic [TAPS*DATA_W-1:0] dout_col;
    logic                   dout_vld;
    logic                   dout_full;
    logic                   dout_sof;
    logic                   dout_eof;
    logic [ROW_W-1:0]       dout_row;
    logic [COL_W-1:0]       dout_col_idx;
    logic                   sync_err;
    logic [1:0]             dbg_state;

    modport master (
        output din, din_vld, din_sof,
        input  dout_col, dout_vld, dout_full, dout_sof, dout_eof,
        input  dout_row, dout_col_idx, sync_err, dbg_state
    );

    modport slave (
        input  din, din_vld, din_sof,
        output dout_col, dout_vld, dout_full, dout_sof, dout_eof,
        output dout_row, dout_col_idx, sync_err, dbg_state
    );
endinterface

// File: rtl/line_window_buf.sv
// line_window_buf
//   Vertical-window line buffer. For every accepted raster pixel it emits, one
//   cycle later, a column of TAPS pixels from the same image column: tap TAPS-1
//   is the current row, tap 0 the row TAPS-1 above. Rows above the top of the
//   frame are filled with zero (BORDER_MODE=0) or with row 0 (BORDER_MODE=1).
//   Ports:
//     vga_clk : sole clock (rising edge)
//     rst     : synchronous, active-high reset
//     bus     : line_window_buf_if.slave (din side in, dout_* / sync_err out)
module line_window_buf #(
    parameter int DATA_W      = 8,
    parameter int TAPS        = 5,
    parameter int COL         = 640,
    parameter int ROW         = 480,
    parameter int BORDER_MODE = 0
) (
    input logic             vga_clk,
    input logic             rst,
    line_window_buf_if.slave bus
);
    localparam int ROW_W  = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int COL_W  = (COL > 1) ? $clog2(COL) : 1;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int NLINES = TAPS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic sof_in, accept, resync, is_eof;

    logic [TAPS*DATA_W-1:0] dout_col_q, dout_col_d;
    logic [ROW_W-1:0]       dout_row_q, dout_row_d;
    logic [COL_W-1:0]       dout_idx_q, dout_idx_d;
    logic dout_vld_q, dout_vld_d, dout_full_q, dout_full_d;
    logic dout_sof_q, dout_sof_d, dout_eof_q, dout_eof_d;
    logic sync_err_q, sync_err_d;

    // A valid sof always restarts the raster at (0,0), whatever the counters say.
    assign sof_in  = bus.din_vld & bus.din_sof;
    assign cur_row = sof_in ? '0 : row_q;
    assign cur_col = sof_in ? '0 : col_q;
    assign is_eof  = (cur_row == ROW_W'(ROW - 1)) && (cur_col == COL_W'(COL - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge vga_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (is_eof)                          state_d = ST_IDLE;
            else if (int'(cur_row) >= TAPS - 1) state_d = ST_RUN;
            else                                 state_d = ST_FILL;
        end
    end

    // ---------------- FSM: outputs ----------------
    // While idle only a sof pixel is taken; inside a frame every valid pixel is.
    always_comb begin
        accept = 1'b0;
        resync = 1'b0;
        case (state_q)
            ST_IDLE: accept = sof_in;
            ST_FILL, ST_RUN: begin
                accept = bus.din_vld;
                resync = sof_in;
            end
            default: begin
                accept = 1'b0;
                resync = 1'b0;
            end
        endcase
    end

    // ---------------- raster counters ----------------
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (cur_col == COL_W'(COL - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(ROW - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // ---------------- line memories ----------------
    // Line k holds row r-1-k of each column; on an accepted pixel every line
    // shifts down by one at the current column (read-before-write).
    logic [DATA_W-1:0] line_rd [NLINES];
    logic [DATA_W-1:0] line_wr [NLINES];

    assign line_wr[0] = bus.din;
    for (genvar k = 1; k < NLINES; k++) begin : g_cascade
        assign line_wr[k] = line_rd[k-1];
    end

    for (genvar k = 0; k < NLINES; k++) begin : g_line
        logic [DATA_W-1:0] mem_q [COL];
        assign line_rd[k] = mem_q[cur_col];
        always_ff @(posedge vga_clk) begin
            if (accept) mem_q[cur_col] <= line_wr[k];
        end
    end

    // ---------------- window assembly with top-border masking ----------------
    logic [DATA_W-1:0]      raw_tap [TAPS];
    logic [TAP_W-1:0]       row0_idx;
    logic [DATA_W-1:0]      border_val;
    logic [TAPS*DATA_W-1:0] window;

    assign raw_tap[TAPS-1] = bus.din;
    for (genvar j = 0; j < TAPS - 1; j++) begin : g_raw
        assign raw_tap[j] = line_rd[TAPS-2-j];
    end

    // Row 0 sits at tap TAPS-1-r; only consulted while r < TAPS-1, so the
    // truncation of cur_row into the tap index never matters.
    assign row0_idx   = TAP_W'(TAPS - 1) - TAP_W'(cur_row);
    assign border_val = (BORDER_MODE == 0) ? '0 : raw_tap[row0_idx];

    // Tap j refers to row r-TAPS+1+j; negative rows lie above the frame and
    // also hide whatever an earlier frame left in the line memories.
    for (genvar j = 0; j < TAPS; j++) begin : g_win
        assign window[j*DATA_W +: DATA_W] =
            (int'(cur_row) + j < TAPS - 1) ? border_val : raw_tap[j];
    end

    // ---------------- output registers ----------------
    always_comb begin
        dout_vld_d  = accept;
        dout_full_d = accept && (int'(cur_row) >= TAPS - 1);
        dout_sof_d  = accept && sof_in;
        dout_eof_d  = accept && is_eof;
        sync_err_d  = resync;
        dout_col_d  = dout_col_q;
        dout_row_d  = dout_row_q;
        dout_idx_d  = dout_idx_q;
        if (accept) begin
            dout_col_d = window;
            dout_row_d = cur_row;
            dout_idx_d = cur_col;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            dout_col_q  <= '0;
            dout_row_q  <= '0;
            dout_idx_q  <= '0;
            dout_vld_q  <= 1'b0;
            dout_full_q <= 1'b0;
            dout_sof_q  <= 1'b0;
            dout_eof_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            dout_col_q  <= dout_col_d;
            dout_row_q  <= dout_row_d;
            dout_idx_q  <= dout_idx_d;
            dout_vld_q  <= dout_vld_d;
            dout_full_q <= dout_full_d;
            dout_sof_q  <= dout_sof_d;
            dout_eof_q  <= dout_eof_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.dout_col     = dout_col_q;
    assign bus.dout_vld     = dout_vld_q;
    assign bus.dout_full    = dout_full_q;
    assign bus.dout_sof     = dout_sof_q;
    assign bus.dout_eof     = dout_eof_q;
    assign bus.dout_row     = dout_row_q;
    assign bus.dout_col_idx = dout_idx_q;
    assign bus.sync_err     = sync_err_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_line_window_buf.sv
// tb_line_window_buf
//   Drives two buffers (BORDER_MODE 0 and 1) with the same pixel stream and
//   checks every cycle against a frame-image reference model.
module tb_line_window_buf;
    localparam int DW   = 8;
    localparam int TAPS = 5;
    localparam int COL  = 8;
    localparam int ROW  = 6;
    localparam int RW   = 3;
    localparam int CW   = 3;

    typedef struct packed {
        logic vld, full, sof, eof, serr, idle, pat;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [TAPS*DW-1:0] col_m0;
        logic [TAPS*DW-1:0] col_m1;
    } exp_t;

    typedef struct packed {
        logic vld, full, sof, eof, serr;
        logic [1:0] st;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [TAPS*DW-1:0] data;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic vga_clk = 1'b0;
    logic rst = 1'b1;
    always #5 vga_clk = ~vga_clk;

    line_window_buf_if #(.DATA_W(DW), .TAPS(TAPS), .COL(COL), .ROW(ROW)) bus0 ();
    line_window_buf_if #(.DATA_W(DW), .TAPS(TAPS), .COL(COL), .ROW(ROW)) bus1 ();

    line_window_buf #(.DATA_W(DW), .TAPS(TAPS), .COL(COL), .ROW(ROW), .BORDER_MODE(0))
        dut0 (.vga_clk(vga_clk), .rst(rst), .bus(bus0));
    line_window_buf #(.DATA_W(DW), .TAPS(TAPS), .COL(COL), .ROW(ROW), .BORDER_MODE(1))
        dut1 (.vga_clk(vga_clk), .rst(rst), .bus(bus1));

    obs_t obs [2];
    assign obs[0] = {bus0.dout_vld, bus0.dout_full, bus0.dout_sof, bus0.dout_eof, bus0.sync_err,
                     bus0.dbg_state, bus0.dout_row, bus0.dout_col_idx, bus0.dout_col};
    assign obs[1] = {bus1.dout_vld, bus1.dout_full, bus1.dout_sof, bus1.dout_eof, bus1.sync_err,
                     bus1.dbg_state, bus1.dout_row, bus1.dout_col_idx, bus1.dout_col};

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vld_cnt  = 0;

    // ---------------- reference model ----------------
    // The model keeps the current frame as a plain image and reads the window
    // straight out of it by row arithmetic.
    logic [DW-1:0] img [ROW][COL];
    bit m_active = 1'b0;
    int m_r = 0;
    int m_c = 0;

    task automatic model_step(input logic vld, input logic sof, input logic [DW-1:0] data,
                              input bit pat, output exp_t e);
        int rr;
        e = '0;
        e.pat = pat;
        if (vld && sof) begin
            e.serr   = m_active;
            m_active = 1'b1;
            m_r      = 0;
            m_c      = 0;
        end
        if (vld && m_active) begin
            e.vld  = 1'b1;
            e.row  = RW'(m_r);
            e.col  = CW'(m_c);
            e.full = (m_r >= TAPS - 1);
            e.sof  = (m_r == 0 && m_c == 0);
            e.eof  = (m_r == ROW - 1 && m_c == COL - 1);
            img[m_r][m_c] = data;
            for (int k = 0; k < TAPS; k++) begin
                rr = m_r - TAPS + 1 + k;
                if (rr < 0) begin
                    e.col_m0[k*DW +: DW] = '0;
                    e.col_m1[k*DW +: DW] = img[0][m_c];
                end else begin
                    e.col_m0[k*DW +: DW] = img[rr][m_c];
                    e.col_m1[k*DW +: DW] = img[rr][m_c];
                end
            end
            m_c++;
            if (m_c == COL) begin
                m_c = 0;
                m_r++;
                if (m_r == ROW) begin
                    m_r      = 0;
                    m_active = 1'b0;
                end
            end
        end
        e.idle = !m_active;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        obs_t o;
        logic [TAPS*DW-1:0] want;
        check_eq("exp_q_size", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            o    = obs[d];
            want = (d == 0) ? e.col_m0 : e.col_m1;
            check_eq($sformatf("dout_vld[%0d]", d), 64'(o.vld), 64'(e.vld));
            check_eq($sformatf("sync_err[%0d]", d), 64'(o.serr), 64'(e.serr));
            check_eq($sformatf("idle[%0d]", d), 64'(o.st == 2'd0), 64'(e.idle));
            if (e.vld) begin
                check_eq($sformatf("dout_col[%0d]", d), 64'(o.data), 64'(want));
                check_eq($sformatf("dout_full[%0d]", d), 64'(o.full), 64'(e.full));
                check_eq($sformatf("dout_sof[%0d]", d), 64'(o.sof), 64'(e.sof));
                check_eq($sformatf("dout_eof[%0d]", d), 64'(o.eof), 64'(e.eof));
                check_eq($sformatf("dout_row[%0d]", d), 64'(o.row), 64'(e.row));
                check_eq($sformatf("dout_col_idx[%0d]", d), 64'(o.col), 64'(e.col));
                // Fixed reference points for the row*16+col pattern.
                if (e.pat && e.row == 3'd4 && e.col == 3'd3)
                    check_eq($sformatf("win_r4c3[%0d]", d), 64'(o.data), 64'(40'h43_33_23_13_03));
                if (e.pat && e.row == 3'd1 && e.col == 3'd2)
                    check_eq($sformatf("win_r1c2[%0d]", d), 64'(o.data),
                             (d == 0) ? 64'(40'h12_02_00_00_00) : 64'(40'h12_02_02_02_02));
                if (e.pat && e.sof)
                    check_eq($sformatf("sof_tap4[%0d]", d), 64'(o.data[TAPS*DW-1 -: DW]), 64'h00);
                if (e.pat && e.eof)
                    check_eq($sformatf("eof_tap4[%0d]", d), 64'(o.data[TAPS*DW-1 -: DW]), 64'h57);
            end
        end
        if (obs[0].vld) vld_cnt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic vld, input logic sof, input logic [DW-1:0] data);
        bus0.din_vld = vld; bus0.din_sof = sof; bus0.din = data;
        bus1.din_vld = vld; bus1.din_sof = sof; bus1.din = data;
    endtask

    task automatic drive_cycle(input logic vld, input logic sof, input logic [DW-1:0] data,
                               input bit pat);
        exp_t e;
        set_inputs(vld, sof, data);
        model_step(vld, sof, data, pat, e);
        exp_q.push_back(e);
        @(posedge vga_clk);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        obs_t o;
        rst = 1'b1;
        set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        repeat (2) @(posedge vga_clk);
        #1;
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, '0);
        m_active = 1'b0;
        m_r = 0;
        m_c = 0;
        exp_q.delete();
        for (int d = 0; d < 2; d++) begin
            o = obs[d];
            check_eq($sformatf("rst_flags[%0d]", d),
                     64'({o.vld, o.full, o.sof, o.eof, o.serr, o.st, o.row, o.col}), 64'd0);
            check_eq($sformatf("rst_dout_col[%0d]", d), 64'(o.data), 64'd0);
        end
    endtask

    task automatic drive_frame(input bit pat, input int max_gap);
        vld_cnt = 0;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                repeat ($urandom_range(0, max_gap))
                    drive_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), pat);
                drive_cycle(1'b1, (r == 0 && c == 0), pat ? 8'(r * 16 + c) : 8'($urandom), pat);
            end
        end
        check_eq("frame_vld_cnt", 64'(vld_cnt), 64'(ROW * COL));
    endtask

    // Pattern pixels from (0,0) up to, but not including, (stop_r, stop_c).
    task automatic drive_partial(input int stop_r, input int stop_c);
        for (int i = 0; i < stop_r * COL + stop_c; i++)
            drive_cycle(1'b1, (i == 0), 8'((i / COL) * 16 + (i % COL)), 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_inputs(1'b0, 1'b0, '0);
        apply_reset();

        // Pixels before any sof are dropped.
        repeat (5) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0);

        // Continuous pattern frame, then a random frame back to back.
        drive_frame(1'b1, 0);
        drive_frame(1'b0, 0);

        // Same pattern with random 0-3 cycle gaps.
        drive_frame(1'b1, 3);
        repeat (2) drive_cycle(1'b0, 1'b0, 8'($urandom), 1'b0);

        // Resync: a new sof arrives at row 3, col 5.
        drive_partial(3, 5);
        drive_frame(1'b1, 0);

        // Reset mid-frame at row 2, stray pixels dropped, then a clean frame.
        drive_partial(2, 3);
        apply_reset();
        repeat (3) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        drive_frame(1'b1, 1);

        repeat (2) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
